alu_serial_ctrl: RTL
====================

# alu_serial_ctrl

Bit-serial sequencer that drives the CPU's 1-bit ALU slice from the other side of its interface. It accepts a full-width operation with two operands and presents one operand bit pair per cycle, LSB first, to the slice. It supplies the slice's invert, carry-in, LESS and operation-select inputs and collects the slice's Result and COUT bits into a parallel result with flags. It lets the datapath use a single slice instead of a 16-slice ripple chain, at the cost of multi-cycle latency.

## Interface
- WIDTH, 16, operand/result width; minimum 2.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low; clears all state.
- Start  input  1  request; sampled only in IDLE.
- Op  input  3  000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT (signed), 110 NOR, 111 reserved (treated as AND).
- A, B  input  WIDTH  operands; latched when Start is accepted.
- Busy  output  1  high in RUN and SLT_FIX.
- Done  output  1  one-cycle pulse in DONE.
- Y  output  WIDTH  result register; holds until the next accepted Start.
- Zero, Carry, Overflow  output  1  result flags; valid from Done and held with Y.
- SliceA, SliceB, SliceLess, SliceCin, SliceAInvert, SliceBInvert  output  1  drive to the slice.
- SliceOperation  output  3  slice mux select: 000 AND, 010 OR, 011 XOR, 100 ADD, 101 LESS.
- SliceResult, SliceCout  input  1  combinational return from the slice, sampled at the same edge.

## Operation
- States: IDLE, RUN, SLT_FIX, DONE.
- Reset state: IDLE. Y, all flags, Busy, Done and all Slice* outputs are 0.
- IDLE with Start=1:
  - Latch A, B and Op.
  - Bit index i <= 0; carry flop <= 1 for SUB/SLT, else 0.
  - Go to RUN.
- Op mapping to {SliceAInvert, SliceBInvert, SliceOperation}:
  - AND: 0,0,000. OR: 0,0,010. XOR: 0,0,011. ADD: 0,0,100.
  - SUB and SLT: 0,1,100.
  - NOR: 1,1,000.
- RUN, each cycle:
  - SliceA = A[i], SliceB = B[i], SliceCin = carry flop, SliceLess = 0.
  - At the edge: Y[i] <= SliceResult; carry flop <= SliceCout; i <= i+1.
- RUN at i = WIDTH-1:
  - Record cin_msb = SliceCin, cout_msb = SliceCout, sum_msb = SliceResult.
  - Go to SLT_FIX if Op = SLT, else to DONE.
- SLT_FIX (one cycle):
  - Drive SliceOperation = 101, SliceA = A[0], SliceB = B[0], inverts 0, SliceCin = 0.
  - Drive SliceLess = sum_msb ^ (cin_msb ^ cout_msb).
  - At the edge: Y <= {WIDTH-1 zeros, SliceResult}.
- Flags, computed on entry to DONE:
  - Zero = (Y == 0) for all ops.
  - Carry = cout_msb for ADD/SUB, else 0.
  - Overflow = cin_msb ^ cout_msb for ADD/SUB, else 0. SLT reports Carry = Overflow = 0.
- DONE: Done=1 for one cycle, then IDLE.
- Start outside IDLE (including the DONE cycle) is ignored, not queued.
- A/B changes after acceptance have no effect.
- In IDLE and DONE all Slice* outputs are 0.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No partial result is retained and no Done is issued.

## Timing
- Start sampled at edge 0.
- RUN occupies cycles 1..WIDTH.
- Done is high in cycle WIDTH+1 for non-SLT ops and in cycle WIDTH+2 for SLT.
- Y and flags are stable from the Done cycle until the edge following the next accepted Start.
- During RUN, Y bits above i hold stale values and must not be consumed.
- Slice path is combinational within one cycle: Slice* outputs → slice → SliceResult/SliceCout → sampling flops.
- Back-to-back throughput: one op per WIDTH+2 cycles (non-SLT) or WIDTH+3 cycles (SLT). Start can be accepted in the cycle after Done.

## Test plan
- ADD, A=0x7FFF, B=0x0001, WIDTH=16, bench models slice → Y=0x8000, Overflow=1, Carry=0, Zero=0. Done only in cycle 17; Busy high in cycles 1–16.
- SUB, A=0x0005, B=0x0007 → Y=0xFFFE, Carry=0, Overflow=0. Then SUB with A=B=0x1234 → Y=0x0000, Zero=1, Carry=1.
- SLT, A=0x8000, B=0x0001 → Y=0x0001, Done in cycle 18. SLT with A=0x7FFF, B=0x8000 (overflow case) → Y=0x0000.
- Logic ops on A=0x0F0F, B=0x00FF:
  - AND → 0x000F; OR → 0x0FFF; XOR → 0x0FF0.
  - NOR → 0xF000, with SliceAInvert = SliceBInvert = 1 throughout RUN.
- Start pulsed at cycle 5 of a RUN with different operands: ignored, and the first result is unchanged. Start held high through DONE: the next op is accepted only in the following IDLE cycle.
- Reset low at cycle 8 of an ADD: Busy, Done, Y, flags and Slice* all 0 immediately. No Done appears after Reset is released. A new ADD then completes correctly.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice: walks the operands LSB first,
// drives the slice controls and assembles the parallel result and flags.
module alu_serial_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_less,
   output logic             slice_cin,
   output logic             slice_a_invert,
   output logic             slice_b_invert,
   output logic [2:0]       slice_operation,
   input  logic             slice_result,
   input  logic             slice_cout
);

   // state   | meaning
   // IDLE    | waiting for start, slice drive idle
   // RUN     | one operand bit pair per cycle, LSB first
   // SLT_FIX | one LESS pass to place the signed compare in bit 0
   // DONE    | one-cycle done pulse, result and flags valid
   typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_t;

   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_NOR = 3'b110;

   localparam logic [2:0] SEL_AND  = 3'b000;
   localparam logic [2:0] SEL_OR   = 3'b010;
   localparam logic [2:0] SEL_XOR  = 3'b011;
   localparam logic [2:0] SEL_ADD  = 3'b100;
   localparam logic [2:0] SEL_LESS = 3'b101;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, y_q, y_d;
   logic [2:0]        op_q, op_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              cin_msb_q, cin_msb_d, cout_msb_q, cout_msb_d, sum_msb_q, sum_msb_d;
   logic              zero_q, zero_d, carry_flag_q, carry_flag_d, ovf_q, ovf_d;
   logic              dec_ai, dec_bi, arith;
   logic [2:0]        dec_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         y_q          <= '0;
         op_q         <= OP_AND;
         idx_q        <= '0;
         carry_q      <= 1'b0;
         cin_msb_q    <= 1'b0;
         cout_msb_q   <= 1'b0;
         sum_msb_q    <= 1'b0;
         zero_q       <= 1'b0;
         carry_flag_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         y_q          <= y_d;
         op_q         <= op_d;
         idx_q        <= idx_d;
         carry_q      <= carry_d;
         cin_msb_q    <= cin_msb_d;
         cout_msb_q   <= cout_msb_d;
         sum_msb_q    <= sum_msb_d;
         zero_q       <= zero_d;
         carry_flag_q <= carry_flag_d;
         ovf_q        <= ovf_d;
      end
   end

   // Slice control decode for the latched op; reserved 111 behaves as AND.
   always_comb begin
      dec_ai  = 1'b0;
      dec_bi  = 1'b0;
      dec_sel = SEL_AND;
      case (op_q)
         OP_OR:          dec_sel = SEL_OR;
         OP_XOR:         dec_sel = SEL_XOR;
         OP_ADD:         dec_sel = SEL_ADD;
         OP_SUB, OP_SLT: begin dec_bi = 1'b1; dec_sel = SEL_ADD; end
         OP_NOR:         begin dec_ai = 1'b1; dec_bi = 1'b1; end
         default:        dec_sel = SEL_AND;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      a_d             = a_q;
      b_d             = b_q;
      y_d             = y_q;
      op_d            = op_q;
      idx_d           = idx_q;
      carry_d         = carry_q;
      cin_msb_d       = cin_msb_q;
      cout_msb_d      = cout_msb_q;
      sum_msb_d       = sum_msb_q;
      zero_d          = zero_q;
      carry_flag_d    = carry_flag_q;
      ovf_d           = ovf_q;
      slice_a         = 1'b0;
      slice_b         = 1'b0;
      slice_less      = 1'b0;
      slice_cin       = 1'b0;
      slice_a_invert  = 1'b0;
      slice_b_invert  = 1'b0;
      slice_operation = 3'b000;
      arith           = (op_q == OP_ADD) || (op_q == OP_SUB);

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               idx_d   = '0;
               carry_d = (op == OP_SUB) || (op == OP_SLT);
               state_d = RUN;
            end
         end
         RUN: begin
            slice_a         = a_q[idx_q];
            slice_b         = b_q[idx_q];
            slice_cin       = carry_q;
            slice_a_invert  = dec_ai;
            slice_b_invert  = dec_bi;
            slice_operation = dec_sel;
            y_d[idx_q]      = slice_result;
            carry_d         = slice_cout;
            idx_d           = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               cin_msb_d  = carry_q;
               cout_msb_d = slice_cout;
               sum_msb_d  = slice_result;
               state_d    = (op_q == OP_SLT) ? SLT_FIX : DONE;
            end
         end
         SLT_FIX: begin
            slice_operation = SEL_LESS;
            slice_a         = a_q[0];
            slice_b         = b_q[0];
            // signed less-than: sign of the difference corrected by overflow
            slice_less      = sum_msb_q ^ (cin_msb_q ^ cout_msb_q);
            y_d             = '0;
            y_d[0]          = slice_result;
            state_d         = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if ((state_d == DONE) && (state_q != DONE)) begin
         zero_d       = (y_d == '0);
         carry_flag_d = arith & cout_msb_d;
         ovf_d        = arith & (cin_msb_d ^ cout_msb_d);
      end
   end

   assign busy     = (state_q == RUN) || (state_q == SLT_FIX);
   assign done     = (state_q == DONE);
   assign y        = y_q;
   assign zero     = zero_q;
   assign carry    = carry_flag_q;
   assign overflow = ovf_q;

endmodule
